// File: rtl/base_ram_arbiter_pkg.sv
// Shared types and constants for the BaseRAM arbiter.
//   state_e    : bus-cycle FSM states
//   gnt_e      : requester encoding, also the bit index in one-hot grants
//   phase_last : terminal count of the phase counter for a given state
package base_ram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  localparam int unsigned WR_SETUP_LEN = 1;
  localparam int unsigned WR_PULSE_LEN = 1;
  localparam int unsigned WR_HOLD_LEN  = 1;
  localparam int unsigned RD_WAIT_MAX  = 7;
  localparam int unsigned CNT_W        = 3;

  // A state ends on the edge where the phase counter equals this value.
  function automatic logic [CNT_W-1:0] phase_last(input state_e s, input int unsigned rd_wait);
    case (s)
      RD:       phase_last = CNT_W'(rd_wait);
      WR_SETUP: phase_last = CNT_W'(WR_SETUP_LEN - 1);
      WR_PULSE: phase_last = CNT_W'(WR_PULSE_LEN - 1);
      WR_HOLD:  phase_last = CNT_W'(WR_HOLD_LEN - 1);
      default:  phase_last = '0;
    endcase
  endfunction

endpackage

// File: rtl/base_ram_arbiter_if.sv
// CPU-side request buses and BaseRAM pin-side signals of the arbiter.
//   inst_* : fetch requester (read-only)
//   data_* : data requester (read/write, byte enables)
//   ram_*  : SRAM address/strobes and split tri-state data bus
// Modports: slave = arbiter side, master = CPU + SRAM side.
interface base_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic              inst_rvalid;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic              data_we;
  logic [3:0]        data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_ready;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be_n;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;
  logic [31:0]       ram_dq_o;
  logic              ram_dq_oe;
  logic [31:0]       ram_dq_i;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_we, data_be, data_addr, data_wdata,
    input  ram_dq_i,
    output inst_ready, inst_rvalid, inst_rdata,
    output data_ready, data_rvalid, data_rdata,
    output ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n, ram_dq_o, ram_dq_oe
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_we, data_be, data_addr, data_wdata,
    output ram_dq_i,
    input  inst_ready, inst_rvalid, inst_rdata,
    input  data_ready, data_rvalid, data_rdata,
    input  ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n, ram_dq_o, ram_dq_oe
  );
endinterface

// File: rtl/base_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : requests, bit index = gnt_e (0 inst, 1 data)
//   advance    : a grant was taken this cycle; remember who won
//   gnt[1:0]   : one-hot grant (combinational)
module rr_arb2
  import base_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  gnt_e last_grant;

  // On contention the winner is whoever did not win last time.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == GNT_INST) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_INST;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? GNT_DATA : GNT_INST;
    end
  end

endmodule

// File: rtl/base_ram_arbiter.sv
// Shares one 32-bit asynchronous SRAM between instruction fetch and data ports.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave modport carrying both request ports and the SRAM pins
// A request is accepted while idle: ready pulses in that cycle and the command is
// latched. The next cycle starts the strobe sequence (read: RD for RD_WAIT+1
// cycles; write: setup, pulse, hold). The cycle that returns to IDLE may
// already accept the next request.
module base_ram_arbiter
  import base_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned RD_WAIT = 1
) (
  input logic               clk,
  input logic               reset,
  base_ram_arbiter_if.slave bus
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              go;       // command latched, bus cycle starts next edge
  gnt_e              owner;
  logic              cmd_we;
  logic [3:0]        cmd_be;
  logic [31:0]       cmd_wdata;

  logic              inst_ready, data_ready, inst_rvalid, data_rvalid;
  logic [31:0]       inst_rdata, data_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be_n;
  logic              ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe;
  logic [31:0]       ram_dq_o;

  logic              phase_end, can_accept, accept;
  logic [1:0]        req, gnt;

  assign phase_end  = (cnt == phase_last(state, RD_WAIT));
  assign can_accept = ((state == IDLE) && !go) ||
                      (phase_end && ((state == RD) || (state == WR_HOLD)));
  assign req        = can_accept ? {bus.data_req, bus.inst_req} : 2'b00;
  assign accept     = (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      go          <= 1'b0;
      owner       <= GNT_INST;
      cmd_we      <= 1'b0;
      cmd_be      <= '0;
      cmd_wdata   <= '0;
      inst_ready  <= 1'b0;
      data_ready  <= 1'b0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
      ram_addr    <= '0;
      ram_be_n    <= 4'hF;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_dq_o    <= '0;
      ram_dq_oe   <= 1'b0;
    end else begin
      inst_ready  <= 1'b0;
      data_ready  <= 1'b0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      cnt         <= cnt + CNT_W'(1);

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (go) begin
            go       <= 1'b0;
            ram_ce_n <= 1'b0;
            if (cmd_we) begin
              state     <= WR_SETUP;
              ram_be_n  <= ~cmd_be;
              ram_dq_o  <= cmd_wdata;
              ram_dq_oe <= 1'b1;
            end else begin
              state    <= RD;
              ram_oe_n <= 1'b0;
              ram_be_n <= 4'h0;
            end
          end
        end
        RD: begin
          if (phase_end) begin
            state    <= IDLE;
            cnt      <= '0;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_be_n <= 4'hF;
            if (owner == GNT_DATA) begin
              data_rdata  <= bus.ram_dq_i;
              data_rvalid <= 1'b1;
            end else begin
              inst_rdata  <= bus.ram_dq_i;
              inst_rvalid <= 1'b1;
            end
          end
        end
        WR_SETUP: begin
          if (phase_end) begin
            state    <= WR_PULSE;
            cnt      <= '0;
            ram_we_n <= 1'b0;
          end
        end
        WR_PULSE: begin
          if (phase_end) begin
            state    <= WR_HOLD;
            cnt      <= '0;
            ram_we_n <= 1'b1;
          end
        end
        WR_HOLD: begin
          if (phase_end) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_ce_n  <= 1'b1;
            ram_be_n  <= 4'hF;
            ram_dq_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        go         <= 1'b1;
        owner      <= gnt[1] ? GNT_DATA : GNT_INST;
        ram_addr   <= gnt[1] ? bus.data_addr : bus.inst_addr;
        cmd_we     <= gnt[1] & bus.data_we;
        cmd_be     <= bus.data_be;
        cmd_wdata  <= bus.data_wdata;
        inst_ready <= gnt[0];
        data_ready <= gnt[1];
      end
    end
  end

  assign bus.inst_ready  = inst_ready;
  assign bus.inst_rvalid = inst_rvalid;
  assign bus.inst_rdata  = inst_rdata;
  assign bus.data_ready  = data_ready;
  assign bus.data_rvalid = data_rvalid;
  assign bus.data_rdata  = data_rdata;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_be_n    = ram_be_n;
  assign bus.ram_ce_n    = ram_ce_n;
  assign bus.ram_oe_n    = ram_oe_n;
  assign bus.ram_we_n    = ram_we_n;
  assign bus.ram_dq_o    = ram_dq_o;
  assign bus.ram_dq_oe   = ram_dq_oe;

endmodule

// File: doc/base_ram_arbiter.md
Name: base_ram_arbiter

Overview:
Shares the single 32-bit asynchronous BaseRAM between two requesters: instruction fetch (read-only) and data (read/write with byte enables).
- Sequences the SRAM control strobes (ce_n/oe_n/we_n/be_n) with fixed setup, pulse and hold cycles.
- Drives the tri-state data bus through separate out, output-enable and in signals; the pad-level inout lives in the board top.
- Sits between the CPU memory interfaces and the board's BaseRAM pins.

Parameters:
ADDR_W, 20, SRAM word-address width.
RD_WAIT, 1, extra wait cycles in a read before data is sampled (0..7).

Ports:
clk  in  1  system clock (50 MHz board clock)
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request; held until inst_ready
inst_addr  in  ADDR_W  fetch word address
inst_ready  out  1  one-cycle accept pulse
inst_rvalid  out  1  one-cycle read-data-valid pulse
inst_rdata  out  32  fetch read data
data_req  in  1  data request; held until data_ready
data_we  in  1  1 = write, 0 = read
data_be  in  4  byte enables (active-high)
data_addr  in  ADDR_W  data word address
data_wdata  in  32  write data
data_ready  out  1  one-cycle accept pulse
data_rvalid  out  1  one-cycle read-data-valid pulse (reads only)
data_rdata  out  32  data read data
ram_addr  out  ADDR_W  SRAM address
ram_be_n  out  4  SRAM byte enables, active-low
ram_ce_n  out  1  SRAM chip enable, active-low
ram_oe_n  out  1  SRAM output enable, active-low
ram_we_n  out  1  SRAM write enable, active-low
ram_dq_o  out  32  bus drive value
ram_dq_oe  out  1  1 = drive bus
ram_dq_i  in  32  bus sampled value

Behaviour:
- All outputs are registered.
- Reset values:
  - ram_ce_n, ram_oe_n, ram_we_n = 1; ram_be_n = 4'hF; ram_dq_oe = 0; ram_addr = 0; ram_dq_o = 0.
  - All ready/rvalid = 0; all rdata = 0.
  - State = IDLE; last_grant = INST.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE, acceptance and arbitration:
  - A request is accepted only in IDLE. The granted requester sees its ready pulse high for exactly that cycle; address, be, we and wdata are captured on that edge.
  - One requester pending: it is granted.
  - Both pending: round-robin. Grant the requester other than last_grant, then update last_grant. No requester waits more than one transaction.
- Read (either port), accepted at cycle T:
  - RD occupies cycles T+1 .. T+1+RD_WAIT.
  - In RD: ce_n = 0, oe_n = 0, we_n = 1, be_n = 0000, dq_oe = 0.
  - ram_dq_i is sampled on the last RD edge into the owner's rdata.
  - The owner's rvalid pulses at cycle T+2+RD_WAIT. The FSM is back in IDLE that same cycle and may accept a new request.
  - Read throughput: one read per RD_WAIT+2 cycles.
- Write (data port only), accepted at cycle T. Each phase lasts 1 cycle; dq_oe = 1 and ram_dq_o = wdata throughout.
  - WR_SETUP at T+1: ce_n = 0, we_n = 1, be_n = ~be.
  - WR_PULSE at T+2: we_n = 0.
  - WR_HOLD at T+3: we_n = 1, ce_n = 0.
  - Back in IDLE at T+4.
  - No rvalid is returned for writes. oe_n stays 1 for the whole write.
- data_be = 0 on a write: the bus cycle still runs with be_n = 4'hF. No bytes change and ready is still pulsed.
- IDLE strobes: ce_n = oe_n = we_n = 1 and dq_oe = 0. ram_addr holds its last value.
- Reset asserted mid-transaction: at the next edge all outputs return to reset values and any pending rvalid is dropped. A write in WR_PULSE is truncated; memory contents at that address are undefined, which is acceptable.
- rdata holds its value until the next read for the same port.
- A request deasserted before ready is a protocol violation; behaviour is undefined.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD);
  - grant encoding (GNT_INST = 0, GNT_DATA = 1);
  - constants for write phase lengths (1 each) and the RD_WAIT upper bound (7).
- One sub-module: rr_arb2. It is a two-input round-robin arbiter with a last_grant register, an advance-on-accept input and a one-hot grant output.
- The FSM and datapath registers stay in base_ram_arbiter.

Test Plan:
1. RD_WAIT = 1; inst read at 0x00010. The SRAM model returns 0xDEADBEEF. Expect inst_ready at T, ce_n/oe_n low at T+1 and T+2, inst_rvalid at T+3 with inst_rdata = 0xDEADBEEF, and data_rvalid never asserted.
2. Data write to addr 0x00020 with be = 0110 and wdata = 0x11223344, then a read of the same address over a memory preset to 0xAABBCCDD. Expect exactly one we_n low cycle at T+2 with be_n = 1001, and readback data = 0xAA2233DD.
3. inst_req and data_req held continuously, all reads. Grants alternate data, inst, data, inst (first to data after reset). Each rvalid goes to the correct port, and a new ready fires every RD_WAIT+2 cycles.
4. Back-to-back data reads to 0x0 and 0x1 with RD_WAIT = 0. The second ready coincides with the first data_rvalid, giving a spacing of 2 cycles.
5. Reset asserted during WR_PULSE. The next cycle shows we_n = ce_n = 1, dq_oe = 0, state IDLE and no ready/rvalid. A subsequent inst read completes normally.
6. Data write with be = 0000. Expect be_n = 4'hF through the write, data_ready still pulsed, memory unchanged on readback, and the FSM back in IDLE at T+4.
